// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the front-panel LED controller and its prescaler.
// Source codes double as the value driven on the src output.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        StStartup = 2'd0,
        StIdle    = 2'd1,
        StStatus  = 2'd2,
        StFlash   = 2'd3
    } led_state_e;

    localparam logic [1:0] SRC_STARTUP = 2'd0;
    localparam logic [1:0] SRC_IDLE    = 2'd1;
    localparam logic [1:0] SRC_STATUS  = 2'd2;
    localparam logic [1:0] SRC_FLASH   = 2'd3;

    localparam logic [7:0] LED_ALL_ON = 8'hFF;
    localparam logic [7:0] LED_OFF    = 8'h00;

    function automatic logic [1:0] state_to_src(input led_state_e st);
        logic [1:0] code;
        code = SRC_STARTUP;
        unique case (st)
            StStartup: code = SRC_STARTUP;
            StIdle:    code = SRC_IDLE;
            StStatus:  code = SRC_STATUS;
            StFlash:   code = SRC_FLASH;
            default:   code = SRC_STARTUP;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/led_tick_prescaler.sv
// Visual-rate tick generator: an accumulating prescaler whose registered carry-out is the tick.
// Also drives the cylon generator's advance so all LED activity shares one time base.
module led_tick_prescaler
    import led_ctrl_pkg::*;
#(
    parameter int unsigned MXPRE = 21
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] rate,
    output logic       tick
);

    logic [MXPRE-1:0] pre_q;
    logic [MXPRE-1:0] pre_d;
    logic             tick_q;
    logic             carry;
    logic [MXPRE:0]   sum;

    // Rate changes apply on the very next add; the accumulator is never cleared.
    always_comb begin
        sum   = {1'b0, pre_q} + (MXPRE + 1)'(rate) + (MXPRE + 1)'(1);
        pre_d = sum[MXPRE-1:0];
        carry = sum[MXPRE];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= carry;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/led_display_ctrl.sv
// Front-panel LED bank arbiter: lamp test, cylon idle, live status and blinking event flashes.
// Outputs are registered from the current state, so they lag a transition decision by one clock.
module led_display_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int unsigned MXPRE         = 21,
    parameter int unsigned STARTUP_TICKS = 4,
    parameter int unsigned HOLD_TICKS    = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] rate,
    input  logic [7:0] cylon_q,
    input  logic [7:0] status_q,
    input  logic       status_en,
    input  logic       flash_req,
    input  logic [7:0] flash_pat,
    input  logic       lamp_test,
    output logic       tick,
    output logic [7:0] led,
    output logic [1:0] src,
    output logic       flash_busy
);

    localparam logic [7:0] StartupLast = 8'(STARTUP_TICKS - 1);
    localparam logic [7:0] HoldLast    = 8'(HOLD_TICKS - 1);

    led_state_e state_q;
    logic [7:0] cnt_q;
    logic [7:0] fpat_q;
    logic [7:0] led_q;
    logic [1:0] src_q;
    logic       busy_q;
    logic [7:0] show_pat;
    logic       tick_w;

    led_tick_prescaler #(
        .MXPRE (MXPRE)
    ) u_prescaler (
        .clock (clock),
        .reset (reset),
        .rate  (rate),
        .tick  (tick_w)
    );

    // Pattern the current state wants on the bus, before the lamp-test override.
    always_comb begin
        show_pat = LED_ALL_ON;
        unique case (state_q)
            StStartup: show_pat = LED_ALL_ON;
            StIdle:    show_pat = cylon_q;
            StStatus:  show_pat = status_q;
            StFlash:   show_pat = cnt_q[0] ? LED_OFF : fpat_q;
            default:   show_pat = LED_ALL_ON;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StStartup;
            cnt_q   <= 8'd0;
            fpat_q  <= 8'd0;
            led_q   <= LED_ALL_ON;
            src_q   <= SRC_STARTUP;
            busy_q  <= 1'b0;
        end else begin
            led_q  <= lamp_test ? LED_ALL_ON : show_pat;
            src_q  <= state_to_src(state_q);
            busy_q <= (state_q == StFlash);

            unique case (state_q)
                StStartup: begin
                    if (tick_w) begin
                        if (cnt_q == StartupLast) begin
                            cnt_q   <= 8'd0;
                            state_q <= status_en ? StStatus : StIdle;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                StIdle: begin
                    if (flash_req) begin
                        state_q <= StFlash;
                        fpat_q  <= flash_pat;
                        cnt_q   <= 8'd0;
                    end else if (status_en) begin
                        state_q <= StStatus;
                    end
                end
                StStatus: begin
                    if (flash_req) begin
                        state_q <= StFlash;
                        fpat_q  <= flash_pat;
                        cnt_q   <= 8'd0;
                    end else if (!status_en) begin
                        state_q <= StIdle;
                    end
                end
                StFlash: begin
                    // A retrigger outranks an exit tick landing in the same cycle.
                    if (flash_req) begin
                        fpat_q <= flash_pat;
                        cnt_q  <= 8'd0;
                    end else if (tick_w) begin
                        if (cnt_q == HoldLast) begin
                            cnt_q   <= 8'd0;
                            state_q <= status_en ? StStatus : StIdle;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                default: state_q <= StStartup;
            endcase
        end
    end

    assign tick       = tick_w;
    assign led        = led_q;
    assign src        = src_q;
    assign flash_busy = busy_q;

endmodule

// File: tb/tb_led_display_ctrl.sv
// Directed bench for led_display_ctrl with MXPRE=4, STARTUP_TICKS=4, HOLD_TICKS=4, rate=3.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_led_display_ctrl;

    logic       clock;
    logic       reset;
    logic [1:0] rate;
    logic [7:0] cylon_q;
    logic [7:0] status_q;
    logic       status_en;
    logic       flash_req;
    logic [7:0] flash_pat;
    logic       lamp_test;
    logic       tick;
    logic [7:0] led;
    logic [1:0] src;
    logic       flash_busy;

    int vectors;
    int miscompares;

    led_display_ctrl #(
        .MXPRE         (4),
        .STARTUP_TICKS (4),
        .HOLD_TICKS    (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rate       (rate),
        .cylon_q    (cylon_q),
        .status_q   (status_q),
        .status_en  (status_en),
        .flash_req  (flash_req),
        .flash_pat  (flash_pat),
        .lamp_test  (lamp_test),
        .tick       (tick),
        .led        (led),
        .src        (src),
        .flash_busy (flash_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Advance to the next falling edge that sees tick high; a missing tick is a failure.
    task automatic sync_tick();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clock);
            if (tick) begin
                seen = 1'b1;
                break;
            end
        end
        vectors++;
        if (seen !== 1'b1) begin
            miscompares++;
            $display("FAIL sync_tick: got no tick within 64 clocks, want a tick");
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; rate = 2'd3; cylon_q = 8'h41; status_q = 8'h00; status_en = 1'b0;
        flash_req = 1'b0; flash_pat = 8'h00; lamp_test = 1'b0;
        #2;
        vectors++;
        if ({led, src, tick, flash_busy} !== {8'hFF, 2'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_outputs: got led=%h src=%0d tick=%b busy=%b want FF 0 0 0",
                     led, src, tick, flash_busy);
        end
        @(negedge clock);
        reset = 1'b0;
        step(1);
        vectors++;
        if ({led, src, tick} !== {8'hFF, 2'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL startup_c1: got led=%h src=%0d tick=%b want FF 0 0", led, src, tick);
        end
        step(2);
        vectors++;
        if (tick !== 1'b0) begin
            miscompares++; $display("FAIL tick_c3: got %b want 0", tick);
        end
        step(1);
        vectors++;
        if (tick !== 1'b1) begin
            miscompares++; $display("FAIL tick_c4: got %b want 1", tick);
        end
        step(1);
        vectors++;
        if (tick !== 1'b0) begin
            miscompares++; $display("FAIL tick_c5: got %b want 0", tick);
        end
        step(12);
        vectors++;
        if ({led, src} !== {8'hFF, 2'd0}) begin
            miscompares++;
            $display("FAIL startup_c17: got led=%h src=%0d want FF 0", led, src);
        end
        step(1);
        vectors++;
        if ({led, src} !== {8'h41, 2'd1}) begin
            miscompares++;
            $display("FAIL idle_entry: got led=%h src=%0d want 41 1", led, src);
        end
        cylon_q = 8'h42;
        step(1);
        vectors++;
        if (led !== 8'h42) begin
            miscompares++; $display("FAIL cylon_pass: got %h want 42", led);
        end
    endtask

    task automatic test_status();
        status_q = 8'hA5; status_en = 1'b1;
        step(1);
        vectors++;
        if (src !== 2'd1) begin
            miscompares++; $display("FAIL status_lag: got src=%0d want 1", src);
        end
        step(1);
        vectors++;
        if ({led, src} !== {8'hA5, 2'd2}) begin
            miscompares++; $display("FAIL status_on: got led=%h src=%0d want A5 2", led, src);
        end
        status_q = 8'h5A;
        step(1);
        vectors++;
        if (led !== 8'h5A) begin
            miscompares++; $display("FAIL status_pass: got %h want 5A", led);
        end
        status_en = 1'b0;
        step(2);
        vectors++;
        if ({led, src} !== {8'h42, 2'd1}) begin
            miscompares++; $display("FAIL status_off: got led=%h src=%0d want 42 1", led, src);
        end
    endtask

    task automatic test_flash();
        status_q = 8'hA5; status_en = 1'b1;
        step(2);
        sync_tick();
        flash_req = 1'b1; flash_pat = 8'h3C;
        step(1);
        flash_req = 1'b0; flash_pat = 8'h00;
        step(1);
        vectors++;
        if ({led, src, flash_busy} !== {8'h3C, 2'd3, 1'b1}) begin
            miscompares++;
            $display("FAIL flash_entry: got led=%h src=%0d busy=%b want 3C 3 1",
                     led, src, flash_busy);
        end
        step(3);
        vectors++;
        if (led !== 8'h3C) begin
            miscompares++; $display("FAIL flash_p0_end: got %h want 3C", led);
        end
        step(1);
        vectors++;
        if (led !== 8'h00) begin
            miscompares++; $display("FAIL flash_p1: got %h want 00", led);
        end
        step(4);
        vectors++;
        if (led !== 8'h3C) begin
            miscompares++; $display("FAIL flash_p2: got %h want 3C", led);
        end
        step(4);
        vectors++;
        if (led !== 8'h00) begin
            miscompares++; $display("FAIL flash_p3: got %h want 00", led);
        end
        step(3);
        vectors++;
        if ({led, src} !== {8'h00, 2'd3}) begin
            miscompares++; $display("FAIL flash_last: got led=%h src=%0d want 00 3", led, src);
        end
        step(1);
        vectors++;
        if ({led, src, flash_busy} !== {8'hA5, 2'd2, 1'b0}) begin
            miscompares++;
            $display("FAIL flash_exit: got led=%h src=%0d busy=%b want A5 2 0",
                     led, src, flash_busy);
        end
    endtask

    task automatic test_back_to_back();
        status_en = 1'b0;
        step(2);
        sync_tick();
        flash_req = 1'b1; flash_pat = 8'h3C; status_en = 1'b1;
        step(1);
        flash_req = 1'b0;
        step(1);
        vectors++;
        if ({led, src} !== {8'h3C, 2'd3}) begin
            miscompares++; $display("FAIL flash_beats_status: got led=%h src=%0d want 3C 3", led, src);
        end
        step(14);
        vectors++;
        if (tick !== 1'b1) begin
            miscompares++; $display("FAIL exit_tick: got %b want 1", tick);
        end
        flash_req = 1'b1; flash_pat = 8'h81;
        step(1);
        flash_req = 1'b0;
        vectors++;
        if ({led, src} !== {8'h00, 2'd3}) begin
            miscompares++; $display("FAIL retrig_c17: got led=%h src=%0d want 00 3", led, src);
        end
        step(1);
        vectors++;
        if ({led, src, flash_busy} !== {8'h81, 2'd3, 1'b1}) begin
            miscompares++;
            $display("FAIL retrig_c18: got led=%h src=%0d busy=%b want 81 3 1",
                     led, src, flash_busy);
        end
        step(3);
        vectors++;
        if (led !== 8'h81) begin
            miscompares++; $display("FAIL retrig_c21: got %h want 81", led);
        end
        step(1);
        vectors++;
        if (led !== 8'h00) begin
            miscompares++; $display("FAIL retrig_c22: got %h want 00", led);
        end
        step(4);
        vectors++;
        if (led !== 8'h81) begin
            miscompares++; $display("FAIL retrig_c26: got %h want 81", led);
        end
        step(4);
        vectors++;
        if (led !== 8'h00) begin
            miscompares++; $display("FAIL retrig_c30: got %h want 00", led);
        end
        step(3);
        vectors++;
        if (src !== 2'd3) begin
            miscompares++; $display("FAIL retrig_c33: got src=%0d want 3", src);
        end
        step(1);
        vectors++;
        if ({led, src} !== {8'hA5, 2'd2}) begin
            miscompares++; $display("FAIL retrig_exit: got led=%h src=%0d want A5 2", led, src);
        end
    endtask

    task automatic test_lamp();
        sync_tick();
        flash_req = 1'b1; flash_pat = 8'hC3;
        step(1);
        flash_req = 1'b0;
        step(5);
        lamp_test = 1'b1;
        step(1);
        vectors++;
        if ({led, src, flash_busy} !== {8'hFF, 2'd3, 1'b1}) begin
            miscompares++;
            $display("FAIL lamp_on: got led=%h src=%0d busy=%b want FF 3 1", led, src, flash_busy);
        end
        step(2);
        vectors++;
        if (led !== 8'hFF) begin
            miscompares++; $display("FAIL lamp_hold: got %h want FF", led);
        end
        lamp_test = 1'b0;
        step(1);
        vectors++;
        if (led !== 8'hC3) begin
            miscompares++; $display("FAIL lamp_release: got %h want C3", led);
        end
        step(7);
        vectors++;
        if (src !== 2'd3) begin
            miscompares++; $display("FAIL lamp_flash_last: got src=%0d want 3", src);
        end
        step(1);
        vectors++;
        if ({led, src} !== {8'hA5, 2'd2}) begin
            miscompares++; $display("FAIL lamp_flash_exit: got led=%h src=%0d want A5 2", led, src);
        end
    endtask

    task automatic test_async_reset();
        sync_tick();
        flash_req = 1'b1; flash_pat = 8'h66;
        step(1);
        flash_req = 1'b0;
        step(4);
        vectors++;
        if ({led, src} !== {8'h66, 2'd3}) begin
            miscompares++; $display("FAIL pre_reset_flash: got led=%h src=%0d want 66 3", led, src);
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if ({led, src, flash_busy, tick} !== {8'hFF, 2'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL async_reset: got led=%h src=%0d busy=%b tick=%b want FF 0 0 0",
                     led, src, flash_busy, tick);
        end
        @(negedge clock);
        reset = 1'b0; flash_req = 1'b1; flash_pat = 8'h99;
        step(1);
        flash_req = 1'b0;
        vectors++;
        if ({led, src} !== {8'hFF, 2'd0}) begin
            miscompares++; $display("FAIL replay_c1: got led=%h src=%0d want FF 0", led, src);
        end
        step(16);
        vectors++;
        if ({led, src} !== {8'hFF, 2'd0}) begin
            miscompares++; $display("FAIL replay_c17: got led=%h src=%0d want FF 0", led, src);
        end
        step(1);
        vectors++;
        if ({led, src, flash_busy} !== {8'hA5, 2'd2, 1'b0}) begin
            miscompares++;
            $display("FAIL replay_exit: got led=%h src=%0d busy=%b want A5 2 0",
                     led, src, flash_busy);
        end
    endtask

    task automatic test_rate_sweep();
        int want [4];
        int n;
        want = '{16, 8, 0, 4};
        for (int r = 0; r < 4; r++) begin
            rate = 2'(r);
            sync_tick();
            for (int k = 0; k < 2; k++) begin
                n = 0;
                do begin
                    @(negedge clock);
                    n++;
                end while (!tick && n < 40);
                vectors++;
                if (r == 2) begin
                    if (n != 5 && n != 6) begin
                        miscompares++;
                        $display("FAIL rate_period r=%0d: got %0d want 5 or 6", r, n);
                    end
                end else if (n != want[r]) begin
                    miscompares++;
                    $display("FAIL rate_period r=%0d: got %0d want %0d", r, n, want[r]);
                end
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_status();
        test_flash();
        test_back_to_back();
        test_lamp();
        test_async_reset();
        test_rate_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 time units, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
